// File: rtl/ovc_class_allocator_pkg.sv
// Shared helpers for the output-VC class allocator: width derivation and
// the reference class-to-VC map for the 2-class, 4-VC configuration.
package ovc_class_allocator_pkg;

    // Ceiling log2, never below 1 so a 1-entry index still has a bit.
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int cw_of(input int c);
        return (c > 1) ? log2(c) : 1;
    endfunction

    function automatic int cvw_of(input int c, input int v);
        return (c == 0) ? v : c * v;
    endfunction

    // class0 -> OVC0/1, class1 -> OVC2/3
    localparam logic [7:0] CLASS_SETTING_2C4V = 8'b1100_0011;

endpackage

// File: rtl/class_ovc_table.sv
// Class lookup: returns the set of output VCs a given message class may use.
module class_ovc_table
    import ovc_class_allocator_pkg::*;
#(
    parameter int V   = 4,
    parameter int C   = 2,
    parameter int CVw = cvw_of(C, V),
    parameter logic [CVw-1:0] CLASS_SETTING = {CVw{1'b1}},
    parameter int Cw  = cw_of(C)
) (
    input  logic [Cw-1:0] i_class,
    output logic [V-1:0]  o_ovc_mask
);

    // Classes at or above C match no table row and so get an empty mask.
    always_comb begin
        o_ovc_mask = '0;
        if (C <= 1) begin
            o_ovc_mask = '1;
        end else begin
            for (int c = 0; c < C; c++) begin
                if (int'(i_class) == c) o_ovc_mask = CLASS_SETTING[c*V +: V];
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: first requester at or after i_ptr (wrapping at N) wins.
module rr_arbiter_n
    import ovc_class_allocator_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = log2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    int w_pos;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = 0;
        for (int off = 0; off < N; off++) begin
            w_pos = int'(i_ptr) + off;
            if (w_pos >= N) w_pos = w_pos - N;
            if (!o_valid && i_req[w_pos]) begin
                o_valid        = 1'b1;
                o_grant[w_pos] = 1'b1;
                o_idx          = PW'(w_pos);
            end
        end
    end

endmodule

// File: rtl/ovc_class_allocator.sv
// Output-VC allocator for one router output port: one registered grant per
// cycle, class-restricted VC choice, busy tracking until tail-flit release.
module ovc_class_allocator
    import ovc_class_allocator_pkg::*;
#(
    parameter int N   = 4,
    parameter int V   = 4,
    parameter int C   = 2,
    parameter int CVw = cvw_of(C, V),
    parameter logic [CVw-1:0] CLASS_SETTING = {CVw{1'b1}},
    parameter int Cw  = cw_of(C)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*Cw-1:0] req_class,
    input  logic [V-1:0]    ovc_release,
    output logic [N-1:0]    grant,
    output logic [V-1:0]    granted_ovc,
    output logic [V-1:0]    ovc_status,
    output logic            release_err
);

    localparam int PW = log2(N);

    logic [N-1:0]  r_grant;
    logic [V-1:0]  r_granted_ovc;
    logic [V-1:0]  r_status;
    logic          r_release_err;
    logic [PW-1:0] r_ptr;

    logic [V-1:0]  w_class_mask [N];
    logic [V-1:0]  w_cand [N];
    logic [N-1:0]  w_elig;
    logic [N-1:0]  w_win;
    logic [PW-1:0] w_win_idx;
    logic          w_win_valid;
    logic [V-1:0]  w_sel;

    // Candidates use registered status, so a VC released this cycle waits one.
    for (genvar gi = 0; gi < N; gi++) begin : g_req
        class_ovc_table #(
            .V(V), .C(C), .CVw(CVw), .CLASS_SETTING(CLASS_SETTING), .Cw(Cw)
        ) u_table (
            .i_class    (req_class[gi*Cw +: Cw]),
            .o_ovc_mask (w_class_mask[gi])
        );
        assign w_cand[gi] = w_class_mask[gi] & ~r_status;
        // Last cycle's winner sits out one cycle so a held req is not regranted.
        assign w_elig[gi] = req[gi] & (|w_cand[gi]) & ~r_grant[gi];
    end

    rr_arbiter_n #(.N(N), .PW(PW)) u_arb (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_win),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

    always_comb begin
        w_sel = '0;
        if (w_win_valid) begin
            for (int v = V - 1; v >= 0; v--) begin
                if (w_cand[w_win_idx][v]) begin
                    w_sel    = '0;
                    w_sel[v] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant       <= '0;
            r_granted_ovc <= '0;
            r_status      <= '0;
            r_release_err <= 1'b0;
            r_ptr         <= '0;
        end else begin
            r_grant       <= w_win;
            r_granted_ovc <= w_sel;
            r_status      <= (r_status & ~ovc_release) | w_sel;
            if (|(ovc_release & ~r_status)) r_release_err <= 1'b1;
            if (w_win_valid) begin
                r_ptr <= (int'(w_win_idx) == N - 1) ? '0 : w_win_idx + 1'b1;
            end
        end
    end

    assign grant       = r_grant;
    assign granted_ovc = r_granted_ovc;
    assign ovc_status  = r_status;
    assign release_err = r_release_err;

endmodule

// File: doc/ovc_class_allocator.md
Name: ovc_class_allocator

Overview:
- Output-VC allocator for one router output port.
- Arbitrates N input-VC requesters, each tagged with a message class, onto the V output VCs of that port.
- Honours the per-class VC permission map and tracks which OVCs are busy until the tail flit releases them.
- Sits between the input-port VC state and the switch allocator; issues at most one OVC grant per cycle.

Parameters:
- N, 4, number of requesters (input VCs competing for this port).
- V, 4, VCs per port.
- C, 2, number of message classes; C<=1 means every class may use every VC.
- CVw, (C==0)?V:C*V, width of CLASS_SETTING.
- CLASS_SETTING, {CVw{1'b1}}, bits [(c+1)*V-1:c*V] give the OVCs class c may use.
- Cw, (C>1)?log2(C):1, class field width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  N  requester i wants an OVC; held until granted.
- req_class  in  N*Cw  class of requester i at bits [(i+1)*Cw-1:i*Cw].
- ovc_release  in  V  one-cycle pulse: tail flit of OVC v has left, so free it.
- grant  out  N  one-hot one-cycle pulse to the winning requester.
- granted_ovc  out  V  one-hot OVC assigned; valid only while |grant.
- ovc_status  out  V  1 = OVC allocated.
- release_err  out  1  sticky; set when a release targets a free OVC.

Behaviour:
- Reset (reset==0, async): grant=0, granted_ovc=0, ovc_status=0, release_err=0, rr pointer=0.
- Candidates per requester: cand_i = class_table[req_class_i] & ~ovc_status.
  - ovc_status is the registered value, so an OVC released this cycle is not allocatable this cycle.
  - Out-of-range class (>=C) gives cand_i=0.
- Eligibility: elig_i = req_i & (cand_i!=0) & ~grant_i.
  - A requester granted last cycle is masked for one cycle, so a held req is never double-granted.
- Arbitration: round-robin over elig starting at the pointer; winner w.
  - Pointer <= w+1 (mod N) only when a grant occurs; otherwise it holds.
- OVC selection: lowest-index set bit of cand_w.
- Latency: registered. A request eligible at edge k produces grant/granted_ovc high during cycle k+1 (one cycle). ovc_status[sel] is set at that same edge k.
- Requester protocol: deassert req, or present a new request, in the cycle after grant. A req still high during the grant cycle is ignored for that cycle by the mask.
- Release: ovc_release[v] clears ovc_status[v] at the next edge.
  - Multiple simultaneous releases are allowed.
  - Release of a free OVC leaves status unchanged and sets release_err.
- Simultaneous release of v and allocation: allocation cannot pick v in the same cycle (status is registered), so no conflict exists.
- No eligible requester: grant=0 and granted_ovc=0 next cycle; status changes only by releases.
- All OVCs of a class busy: requests of that class stall indefinitely. No timeout.
- Reset mid-operation: all allocations are lost and the pointer returns to 0. Upstream must also be reset.
- Widths: pointer is log2(N) bits and wraps at N (N need not be a power of two). N=1 degenerates to a fixed grant.

Decomposition:
- Shared package: log2 function, Cw/CVw derivation, example CLASS_SETTING constants used by benches.
- Reuse class_ovc_table: one instance per requester for the class lookup.
- New sub-module rr_arbiter_n (N requests, priority pointer, one-hot grant plus index output). The OVC-pick priority encoder stays inline.

Test Plan:
- All tests use N=4, V=4, C=2, CLASS_SETTING=8'b1100_0011 (class0 → OVC0/1, class1 → OVC2/3).
- Reset then idle → grant=0, ovc_status=4'b0000, release_err=0.
- req=4'b0001, class0 → next cycle grant=0001, granted_ovc=0001, status=0001; req held one more cycle → no second grant.
- req=4'b1111, classes {1,1,0,0} held → four grants on consecutive cycles in order 0,1,2,3; OVCs 0001, 0010, 0100, 1000; status=1111.
- Status=0011, class0 request pending → no grant; pulse ovc_release=0010 → OVC1 is granted one cycle after status clears (two cycles after the pulse).
- ovc_release=0100 while status=0000 → release_err=1 and stays 1; status unchanged.
- Assert reset low mid-grant with status=1010 → grant, status and err clear asynchronously; the pointer restarts at requester 0.
